// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - sequential 16x16 sprite reader with latency-absorbing output FIFO
//
// Walks the 256 pixels of one sprite in row-major order, issues reads to the
// synchronous sprite RAM and streams the returned pixels with their (x, y)
// coordinates through a 4-deep show-ahead FIFO with registered outputs.
//
// Parameters:
//   RD_LATENCY  cycles from a mem_rden_o cycle to valid mem_q_i (1..3)
//   KEY_COLOR   transparency key colour, used only with SPRITE_FETCH_KEY_EN
//
// Optional feature macro: SPRITE_FETCH_KEY_EN
//   defined   - pixels equal to KEY_COLOR are dropped and never presented
//   undefined - all 256 pixels are presented
//
// Ports:
//   clock_i      clock, rising edge
//   reset_i      synchronous active-high reset
//   start_i      fetch request, sampled only while busy_o=0
//   sprite_id_i  sprite to fetch, latched when start_i is accepted
//   busy_o       fetch in progress
//   done_o       one-cycle pulse after the last pixel is handed off
//   mem_rden_o   read strobe to the sprite RAM
//   mem_addr_o   {sprite_id, y, x}
//   mem_q_i      RAM read data, valid RD_LATENCY cycles after mem_rden_o
//   pix_valid_o  pix_* fields hold a pixel
//   pix_ready_i  downstream accepts the pixel
//   pix_x_o      pixel column
//   pix_y_o      pixel row
//   pix_data_o   RGB888 pixel

module sprite_fetch #(
    parameter int          RD_LATENCY = 2,
    parameter logic [23:0] KEY_COLOR  = 24'hFF00FF
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [4:0]  sprite_id_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        mem_rden_o,
    output logic [12:0] mem_addr_o,
    input  logic [23:0] mem_q_i,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic [3:0]  pix_x_o,
    output logic [3:0]  pix_y_o,
    output logic [23:0] pix_data_o
);

    localparam int L = RD_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  id_q, id_d;
    logic        done_q, done_d;

    // read pipeline: valid bit and {y, x} tag per outstanding read
    logic [L-1:0] inflt_q;
    logic [7:0]   tag_q [L];
    logic [2:0]   inflt_cnt;

    // show-ahead FIFO as a shift register; slot 0 is the output register
    logic [31:0] slot_q [4];
    logic [31:0] slot_d [4];
    logic [3:0]  vld_q, vld_d;
    logic [2:0]  fifo_cnt;
    logic [2:0]  wr_pos;
    logic [3:0]  occ;

    logic rden;
    logic push;
    logic pop;
    logic ret_valid;

    assign ret_valid = inflt_q[L-1];
    assign pop       = vld_q[0] & pix_ready_i;

`ifdef SPRITE_FETCH_KEY_EN
    assign push = ret_valid & (mem_q_i != KEY_COLOR);
`else
    logic key_color_unused;
    assign key_color_unused = ^KEY_COLOR;
    assign push = ret_valid;
`endif

    always_comb begin
        inflt_cnt = '0;
        for (int k = 0; k < L; k++) begin
            inflt_cnt = inflt_cnt + 3'(inflt_q[k]);
        end
        fifo_cnt = 3'(vld_q[0]) + 3'(vld_q[1]) + 3'(vld_q[2]) + 3'(vld_q[3]);
    end

    // Credit the pop of this cycle so a full pipeline at RD_LATENCY=3 still
    // sustains one read per cycle; every slot reserved here is either already
    // in the FIFO or will land in it, so the FIFO cannot overflow.
    assign occ = 4'(fifo_cnt) + 4'(inflt_cnt) - 4'(pop);

    // ---------------- FSM ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            id_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        done_d  = 1'b0;
        rden    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    id_d    = sprite_id_i;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                rden = (occ < 4'd4);
                if (rden) begin
                    if (cnt_q == 8'hFF) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                // finish when nothing is in flight and the FIFO empties this cycle
                if (inflt_q == '0 && !vld_q[1] && (!vld_q[0] || pop)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- read tag pipeline ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            inflt_q <= '0;
            for (int k = 0; k < L; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            inflt_q[0] <= rden;
            tag_q[0]   <= cnt_q;
            for (int k = 1; k < L; k++) begin
                inflt_q[k] <= inflt_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
        end
    end

    // ---------------- output FIFO ----------------
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end
        vld_d  = vld_q;
        wr_pos = fifo_cnt - 3'(pop);
        if (pop) begin
            for (int i = 0; i < 3; i++) begin
                slot_d[i] = slot_q[i+1];
            end
            vld_d = {1'b0, vld_q[3:1]};
        end
        if (push) begin
            slot_d[wr_pos[1:0]] = {tag_q[L-1], mem_q_i};
            vld_d[wr_pos[1:0]]  = 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            vld_q <= '0;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign mem_rden_o  = rden;
    assign mem_addr_o  = {id_q, cnt_q};
    assign pix_valid_o = vld_q[0];
    assign pix_y_o     = slot_q[0][31:28];
    assign pix_x_o     = slot_q[0][27:24];
    assign pix_data_o  = slot_q[0][23:0];

endmodule

// File: tb/tb_sprite_fetch.sv
// tb/tb_sprite_fetch.sv - directed self-checking bench for sprite_fetch

module tb_sprite_fetch;

`ifdef SPRITE_FETCH_KEY_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [23:0] mem [0:8191];

    // main instance, RD_LATENCY=2
    logic        start0, busy0, done0, rden0, pv0, ready0;
    logic [4:0]  id0;
    logic [12:0] addr0;
    logic [23:0] q0, pd0;
    logic [3:0]  px0, py0;
    logic [23:0] p0 [0:1];

    // RD_LATENCY=1 and 3 instances for latency timing
    logic        start1, busy1, done1, rden1, pv1;
    logic [12:0] addr1;
    logic [23:0] q1, pd1;
    logic [3:0]  px1, py1;
    logic [23:0] p1;

    logic        start3, busy3, done3, rden3, pv3;
    logic [12:0] addr3;
    logic [23:0] q3, pd3;
    logic [3:0]  px3, py3;
    logic [23:0] p3 [0:2];

    sprite_fetch #(.RD_LATENCY(2)) u0 (
        .clock_i(clk), .reset_i(rst), .start_i(start0), .sprite_id_i(id0),
        .busy_o(busy0), .done_o(done0), .mem_rden_o(rden0), .mem_addr_o(addr0),
        .mem_q_i(q0), .pix_valid_o(pv0), .pix_ready_i(ready0),
        .pix_x_o(px0), .pix_y_o(py0), .pix_data_o(pd0)
    );

    sprite_fetch #(.RD_LATENCY(1)) u1 (
        .clock_i(clk), .reset_i(rst), .start_i(start1), .sprite_id_i(5'd9),
        .busy_o(busy1), .done_o(done1), .mem_rden_o(rden1), .mem_addr_o(addr1),
        .mem_q_i(q1), .pix_valid_o(pv1), .pix_ready_i(1'b1),
        .pix_x_o(px1), .pix_y_o(py1), .pix_data_o(pd1)
    );

    sprite_fetch #(.RD_LATENCY(3)) u3 (
        .clock_i(clk), .reset_i(rst), .start_i(start3), .sprite_id_i(5'd9),
        .busy_o(busy3), .done_o(done3), .mem_rden_o(rden3), .mem_addr_o(addr3),
        .mem_q_i(q3), .pix_valid_o(pv3), .pix_ready_i(1'b1),
        .pix_x_o(px3), .pix_y_o(py3), .pix_data_o(pd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models; the pipelines are never reset so stale data keeps returning
    always @(posedge clk) begin
        p0[0] <= rden0 ? mem[addr0] : 24'h0BAD00;
        p0[1] <= p0[0];
        p1    <= rden1 ? mem[addr1] : 24'h0BAD01;
        p3[0] <= rden3 ? mem[addr3] : 24'h0BAD03;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign q0 = p0[1];
    assign q1 = p1;
    assign q3 = p3[2];

    function automatic logic [23:0] word(input int a);
        int n;
        n = a % 256;
        if ((a / 256) == 3 && (n % 25) == 7 && n < 250) return 24'hFF00FF;
        return 24'(a);
    endfunction

    function automatic bit is_key(input int id, input int n);
        return KEY_EN && (word(id * 256 + n) == 24'hFF00FF);
    endfunction

    function automatic int skip(input int id, input int n);
        int m;
        m = n;
        while (m < 256 && is_key(id, m)) m++;
        return m;
    endfunction

    function automatic int exp_count(input int id);
        int c;
        c = 0;
        for (int n = 0; n < 256; n++) if (!is_key(id, n)) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_rden", rden0, 0);
        check("rst_addr", addr0, 0);
        check("rst_pix_valid", pv0, 0);
        check("rst_pix_x", px0, 0);
        check("rst_pix_y", py0, 0);
        check("rst_pix_data", pd0, 0);
    endtask

    // Caller is in cycle T (inputs phase); start is applied in this cycle.
    // mode 0: ready held high, mode 1: ready toggles every cycle.
    task automatic run0(input int id, input int mode, input int inj_at,
                        input int abort_at, input int exp_done);
        int n_rd, n_live, n_xf, nxt, first_v, done_k;
        bit hold, aborted;
        logic [31:0] held;
        start0 = 1'b1;
        id0    = 5'(id);
        ready0 = 1'b1;
        #1;
        check("start_busy_low", busy0, 0);
        n_rd = 0; n_live = 0; n_xf = 0; first_v = -1; done_k = -1;
        hold = 1'b0; aborted = 1'b0; held = '0;
        nxt = skip(id, 0);
        for (int k = 1; k <= 1500; k++) begin
            tick();
            start0 = (k == inj_at);
            if (k == inj_at) id0 = 5'd31;
            ready0 = (mode == 0) ? 1'b1 : ((k % 2) == 1);
            #1;
            if (k == 1) begin
                check("first_busy", busy0, 1);
                check("first_rden", rden0, 1);
                check("first_addr", addr0, 32'(id * 256));
                check("first_done_low", done0, 0);
            end
            if (hold) begin
                check("stall_valid", pv0, 1);
                check("stall_fields", {py0, px0, pd0}, held);
            end
            if (n_live - n_xf > 4) check("occupancy", n_live - n_xf, 4);
            if (rden0) begin
                if (n_rd > 255) check("extra_read", n_rd, 255);
                check("read_addr", addr0, 32'(id * 256 + (n_rd % 256)));
                if (!is_key(id, n_rd % 256)) n_live++;
                n_rd++;
            end
            if (pv0 && first_v < 0) first_v = k;
            if (done0) check("done_with_valid", pv0, 0);
            if (pv0 && ready0) begin
                check("pix_x", px0, nxt % 16);
                check("pix_y", py0, nxt / 16);
                check("pix_data", pd0, word(id * 256 + nxt));
                n_xf++;
                nxt  = skip(id, nxt + 1);
                hold = 1'b0;
            end else if (pv0) begin
                hold = 1'b1;
                held = {py0, px0, pd0};
            end else begin
                hold = 1'b0;
            end
            if (abort_at > 0 && n_xf == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (done0) begin
                done_k = k;
                break;
            end
        end
        if (!aborted) begin
            check("done_seen", done_k >= 0, 1);
            if (exp_done >= 0) check("done_time", done_k, exp_done);
            check("done_busy_low", busy0, 0);
            check("xfer_count", n_xf, exp_count(id));
            check("read_count", n_rd, 256);
            check("first_valid_latency", first_v >= 4, 1);
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int d1, d3, n1, n3;
        total = 0;
        bad   = 0;
        for (int a = 0; a < 8192; a++) mem[a] = word(a);
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start3 = 1'b0;
        id0 = 5'd0; ready0 = 1'b1;

        // reset state
        repeat (3) tick();
        #1;
        check_reset_vals();
        check("rst_busy1", busy1, 0);
        check("rst_busy3", busy3, 0);
        rst = 1'b0;

        // basic fetch of sprite 5, done at T+260
        tick();
        run0(5, 0, 0, 0, 260);

        // start in the done cycle; ignored start with sprite 31 mid-fetch
        run0(2, 0, 50, 0, 260);
        tick();
        #1;
        check("ignored_start_idle", busy0, 0);
        check("ignored_start_rden", rden0, 0);

        // backpressure
        tick();
        run0(7, 1, 0, 0, -1);

        // reset at pixel 100, then fetch sprite 0 immediately
        tick();
        run0(5, 0, 0, 100, -1);
        tick();
        start0 = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_vals();
        run0(0, 0, 0, 0, 260);

        // sprite 3 holds ten key-coloured pixels
        tick();
        run0(3, 0, 0, 0, 260);

        // RD_LATENCY 1 and 3 done timing
        tick();
        start1 = 1'b1;
        start3 = 1'b1;
        d1 = -1; d3 = -1; n1 = 0; n3 = 0;
        for (int k = 1; k <= 600; k++) begin
            tick();
            start1 = 1'b0;
            start3 = 1'b0;
            #1;
            if (pv1) begin
                check("lat1_data", pd1, word(9 * 256 + n1));
                n1++;
            end
            if (pv3) begin
                check("lat3_data", pd3, word(9 * 256 + n3));
                n3++;
            end
            if (done1 && d1 < 0) d1 = k;
            if (done3 && d3 < 0) d3 = k;
            if (d1 >= 0 && d3 >= 0) break;
        end
        check("lat1_done_time", d1, 259);
        check("lat3_done_time", d3, 261);
        check("lat1_count", n1, 256);
        check("lat3_count", n3, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
